// File: rtl/instruction_fetch.sv
// RV32 fetch stage: PC, req/ack instruction-memory handshake, IF/ID register and one-entry hold buffer.
// Define FETCH_STATS_EN to build the 32-bit delivered-instruction counter on fetch_count.
module instruction_fetch #(
  parameter int unsigned         PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter logic [31:0]         NOP_INSTR = 32'h00000013
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic                if_id_valid,
  output logic [31:0]         if_id_instr,
  output logic [PC_WIDTH-1:0] if_id_pc,
  output logic [6:0]          opcode,
  output logic [31:0]         fetch_count
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_KILL} state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] kill_addr_q, kill_addr_d;
  logic                valid_q, valid_d;
  logic [31:0]         instr_q, instr_d;
  logic [PC_WIDTH-1:0] ifpc_q, ifpc_d;
  logic [31:0]         hold_instr_q, hold_instr_d;
  logic [PC_WIDTH-1:0] hold_pc_q, hold_pc_d;
  logic                if_id_load;

  logic [PC_WIDTH-1:0] target_aligned;
  logic [PC_WIDTH-1:0] pc_inc;

  assign target_aligned = {branch_target[PC_WIDTH-1:2], 2'b00};
  assign pc_inc         = pc_q + PC_WIDTH'(4);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      kill_addr_q  <= RESET_PC;
      valid_q      <= 1'b0;
      instr_q      <= NOP_INSTR;
      ifpc_q       <= '0;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_addr_q  <= kill_addr_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      ifpc_q       <= ifpc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_addr_d  = kill_addr_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    ifpc_d       = ifpc_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    if_id_load   = 1'b0;
    imem_req     = 1'b0;
    imem_addr    = pc_q;

    case (state_q)
      S_IDLE: state_d = S_REQ;

      S_REQ: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          pc_d    = target_aligned;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          // An unacked request must still complete; KILL remembers its address.
          if (!imem_ack) begin
            state_d     = S_KILL;
            kill_addr_d = pc_q;
          end
        end else if (imem_ack && !stall) begin
          valid_d    = 1'b1;
          instr_d    = imem_rdata;
          ifpc_d     = pc_q;
          pc_d       = pc_inc;
          if_id_load = 1'b1;
        end else if (imem_ack) begin
          hold_instr_d = imem_rdata;
          hold_pc_d    = pc_q;
          pc_d         = pc_inc;
          state_d      = S_HOLD;
        end else if (!stall) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end
      end

      S_HOLD: begin
        if (branch_taken) begin
          pc_d    = target_aligned;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          state_d = S_REQ;
        end else if (!stall) begin
          valid_d    = 1'b1;
          instr_d    = hold_instr_q;
          ifpc_d     = hold_pc_q;
          if_id_load = 1'b1;
          state_d    = S_REQ;
        end
      end

      S_KILL: begin
        imem_req  = 1'b1;
        imem_addr = kill_addr_q;
        if (branch_taken) begin
          pc_d    = target_aligned;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end
        if (imem_ack) state_d = S_REQ;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign if_id_valid = valid_q;
  assign if_id_instr = instr_q;
  assign if_id_pc    = ifpc_q;
  assign opcode      = instr_q[6:0];

`ifdef FETCH_STATS_EN
  logic [31:0] count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          count_q <= '0;
    else if (if_id_load) count_q <= count_q + 32'd1;
  end

  assign fetch_count = count_q;
`else
  logic unused_if_id_load;
  assign unused_if_id_load = if_id_load;
  assign fetch_count       = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a randomized run
// scored against an in-order program-stream model (sequential PCs, redirected by branches).
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [6:0]  opcode;
  logic [31:0] fetch_count;

  logic        w_stall;
  logic        w_branch;
  logic [31:0] w_target;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [6:0]  w_opcode;
  logic [31:0] w_count;

  logic        use_fixed;
  logic [31:0] fixed_rdata;
  logic        rand_on;

  int          n_checks;
  int          n_fail;
  int          consumed;
  logic [31:0] sb_q[$];
  logic [31:0] mon_pc;
  logic [31:0] mon_word;

  instruction_fetch #(
    .PC_WIDTH (32),
    .RESET_PC (32'h00000000),
    .NOP_INSTR(32'h00000013)
  ) u_dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .if_id_valid  (if_id_valid),
    .if_id_instr  (if_id_instr),
    .if_id_pc     (if_id_pc),
    .opcode       (opcode),
    .fetch_count  (fetch_count)
  );

  instruction_fetch #(
    .PC_WIDTH (32),
    .RESET_PC (32'hFFFFFFFC),
    .NOP_INSTR(32'h00000013)
  ) u_wrap (
    .clock        (clock),
    .reset        (reset),
    .stall        (w_stall),
    .branch_taken (w_branch),
    .branch_target(w_target),
    .imem_req     (w_req),
    .imem_addr    (w_addr),
    .imem_ack     (w_ack),
    .imem_rdata   (w_rdata),
    .if_id_valid  (w_valid),
    .if_id_instr  (w_instr),
    .if_id_pc     (w_pc),
    .opcode       (w_opcode),
    .fetch_count  (w_count)
  );

  assign w_stall  = 1'b0;
  assign w_branch = 1'b0;
  assign w_target = 32'h0;
  assign w_ack    = 1'b1;
  assign w_rdata  = 32'h00A00093;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  always_comb imem_rdata = use_fixed ? fixed_rdata : mem_word(imem_addr);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    imem_ack      = 1'b0;
    use_fixed     = 1'b1;
    fixed_rdata   = 32'h00A00093;
    step();
    step();
    reset = 1'b1;
  endtask

  // Decode consumes IF/ID on every edge it is valid, unstalled and not flushed.
  always @(negedge clock) begin
    if (rand_on && reset) begin
      if (if_id_valid && !stall && !branch_taken) begin
        if (sb_q.size() == 0) begin
          check("sb_empty", 32'd1, 32'd0);
        end else begin
          mon_pc   = sb_q.pop_front();
          mon_word = mem_word(mon_pc);
          check("rand_pc", if_id_pc, mon_pc);
          check("rand_instr", if_id_instr, mon_word);
          check("rand_opcode", {25'd0, opcode}, {25'd0, mon_word[6:0]});
          sb_q.push_back(mon_pc + 32'd4);
          consumed++;
        end
      end
      if (!if_id_valid) check("rand_bubble", if_id_instr, NOP);
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    consumed = 0;
    rand_on  = 1'b0;

    // Reset state, back-to-back fetch, wrap instance
    do_reset();
    imem_ack = 1'b1;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'd0, if_id_valid}, 32'd0);
    check("rst_instr", if_id_instr, NOP);
    check("rst_pc", if_id_pc, 32'h0);
    check("rst_opcode", {25'd0, opcode}, 32'h13);
    check("rst_count", fetch_count, 32'h0);
    step();
    check("t1_req", {31'd0, imem_req}, 32'd1);
    check("t1_valid_first", {31'd0, if_id_valid}, 32'd0);
    check("t5_addr0", w_addr, 32'hFFFFFFFC);
    for (int i = 0; i < 10; i++) begin
      step();
      check("t1_valid", {31'd0, if_id_valid}, 32'd1);
      check("t1_pc", if_id_pc, 32'(4 * i));
      check("t1_instr", if_id_instr, 32'h00A00093);
      check("t1_opcode", {25'd0, opcode}, 32'h13);
      if (i == 0) begin
        check("t5_addr1", w_addr, 32'h00000000);
        check("t5_pc", w_pc, 32'hFFFFFFFC);
        check("t5_valid", {31'd0, w_valid}, 32'd1);
      end
    end
`ifdef FETCH_STATS_EN
    check("t1_count", fetch_count, 32'd10);
`else
    check("t1_count", fetch_count, 32'd0);
`endif

    // Multi-cycle memory latency at 0x10
    do_reset();
    imem_ack = 1'b1;
    step();
    for (int i = 0; i < 4; i++) step();
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_addr", imem_addr, 32'h10);
      check("t2_req", {31'd0, imem_req}, 32'd1);
      check("t2_valid", {31'd0, if_id_valid}, 32'd0);
      check("t2_bubble", if_id_instr, NOP);
    end
    imem_ack = 1'b1;
    step();
    check("t2_valid_after", {31'd0, if_id_valid}, 32'd1);
    check("t2_pc_after", if_id_pc, 32'h10);

    // Stall on the ack edge goes through the hold buffer
    do_reset();
    imem_ack = 1'b1;
    step();
    step();
    step();
    stall       = 1'b1;
    fixed_rdata = 32'h00B50533;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t3_req", {31'd0, imem_req}, 32'd0);
      check("t3_pc_held", if_id_pc, 32'h4);
      check("t3_valid_held", {31'd0, if_id_valid}, 32'd1);
    end
    stall    = 1'b0;
    imem_ack = 1'b0;
    step();
    check("t3_valid", {31'd0, if_id_valid}, 32'd1);
    check("t3_pc", if_id_pc, 32'h8);
    check("t3_instr", if_id_instr, 32'h00B50533);
    check("t3_next_req", {31'd0, imem_req}, 32'd1);
    check("t3_next_addr", imem_addr, 32'hC);
    step();
    check("t3_once", {31'd0, if_id_valid}, 32'd0);
    check("t3_addr_wait", imem_addr, 32'hC);
`ifdef FETCH_STATS_EN
    check("t3_count", fetch_count, 32'd3);
`else
    check("t3_count", fetch_count, 32'd0);
`endif

    // Branch during an unacked request
    do_reset();
    imem_ack = 1'b1;
    step();
    for (int i = 0; i < 8; i++) step();
    check("t4_pc_pre", if_id_pc, 32'h1C);
    check("t4_addr_pre", imem_addr, 32'h20);
    imem_ack = 1'b0;
    step();
    branch_taken  = 1'b1;
    branch_target = 32'h42;
    step();
    branch_taken = 1'b0;
    check("t4_kill_valid", {31'd0, if_id_valid}, 32'd0);
    check("t4_kill_req", {31'd0, imem_req}, 32'd1);
    check("t4_kill_addr", imem_addr, 32'h20);
    step();
    check("t4_kill_addr2", imem_addr, 32'h20);
    imem_ack    = 1'b1;
    fixed_rdata = 32'hDEADBEEF;
    step();
    check("t4_drop_valid", {31'd0, if_id_valid}, 32'd0);
    check("t4_drop_instr", if_id_instr, NOP);
    check("t4_new_addr", imem_addr, 32'h40);
    fixed_rdata = 32'h00C00113;
    step();
    check("t4_first_valid", {31'd0, if_id_valid}, 32'd1);
    check("t4_first_pc", if_id_pc, 32'h40);
    check("t4_first_instr", if_id_instr, 32'h00C00113);

    // Asynchronous reset while a request is waiting
    do_reset();
    imem_ack    = 1'b1;
    fixed_rdata = 32'h00B50533;
    step();
    step();
    step();
    stall    = 1'b1;
    imem_ack = 1'b0;
    step();
    check("t6_pre_opcode", {25'd0, opcode}, 32'h33);
    check("t6_pre_req", {31'd0, imem_req}, 32'd1);
    #3;
    reset = 1'b0;
    #1;
    check("t6_req", {31'd0, imem_req}, 32'd0);
    check("t6_valid", {31'd0, if_id_valid}, 32'd0);
    check("t6_opcode", {25'd0, opcode}, 32'h13);
    check("t6_count", fetch_count, 32'd0);
    check("t6_addr", imem_addr, 32'h0);
    stall = 1'b0;

    // Randomized run against the program-stream model
    do_reset();
    use_fixed = 1'b0;
    sb_q.delete();
    sb_q.push_back(32'h0);
    rand_on = 1'b1;
    step();
    step();
    for (int i = 0; i < 3000; i++) begin
      imem_ack = ($urandom_range(0, 99) < 60);
      stall    = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 99) < 4) begin
        branch_taken  = 1'b1;
        branch_target = $urandom;
        sb_q.delete();
        sb_q.push_back(branch_target & ~32'h3);
      end else begin
        branch_taken = 1'b0;
      end
      step();
    end
    rand_on      = 1'b0;
    branch_taken = 1'b0;
    stall        = 1'b0;
    check("rand_progress", {31'd0, consumed > 300}, 32'd1);
`ifndef FETCH_STATS_EN
    check("rand_count", fetch_count, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
